// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer around the SIPO deserialiser: feeds symbols in,
// captures each parallel word on done and hands it downstream.
module sipo_frame_ctrl #(
  parameter int SIZE_DATA_IN  = 1,
  parameter int SIZE_DATA_OUT = 8,
  parameter int FRAME_LEN_W   = 8,
  parameter int DONE_TIMEOUT  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic [FRAME_LEN_W-1:0]   i_frame_len,
  input  logic                     i_s_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_s_data,
  output logic                     o_s_ready,
  output logic                     o_sipo_start,
  output logic [SIZE_DATA_IN-1:0]  o_sipo_data,
  input  logic [SIZE_DATA_OUT-1:0] i_sipo_data,
  input  logic                     i_sipo_done,
  output logic                     o_m_valid,
  output logic [SIZE_DATA_OUT-1:0] o_m_data,
  output logic                     o_m_last,
  input  logic                     i_m_ready,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_err
);

  localparam int SYM = SIZE_DATA_OUT / SIZE_DATA_IN;
  localparam int SCW = $clog2(SYM + 1);
  localparam int TCW =
    (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(DONE_TIMEOUT - 1);
  localparam logic [FRAME_LEN_W-1:0] ONE_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_DONE,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [FRAME_LEN_W-1:0] len_q;
  logic [FRAME_LEN_W-1:0] wcnt_q;
  logic [SCW-1:0]         scnt_q;
  logic [TCW-1:0]         tcnt_q;
  logic [SIZE_DATA_OUT-1:0] m_data_q;
  logic                   err_q;
  logic                   fdone_q;

  logic accept;
  logic last_acc;
  logic hs;
  logic is_last;
  logic start_ok;
  logic start_bad;
  logic to_hit;
  logic early_bad;
  logic capture;

  assign accept    = i_s_valid && (state_q == SHIFT);
  assign last_acc  = accept && (scnt_q == SYM_LAST);
  assign hs        = (state_q == OUT) && i_m_ready;
  assign is_last   = (wcnt_q == (len_q - ONE_W));
  assign start_ok  = (state_q == IDLE) && i_frame_start
                     && (i_frame_len != '0);
  assign start_bad = (state_q == IDLE) && i_frame_start
                     && (i_frame_len == '0);
  assign to_hit    = (state_q == WAIT_DONE) && !i_sipo_done
                     && (tcnt_q == TO_LAST);
  // done while still shifting is only legal on the final symbol
  assign early_bad = (state_q == SHIFT) && i_sipo_done
                     && !last_acc;
  assign capture   = ((state_q == SHIFT) && i_sipo_done && last_acc)
                     || ((state_q == WAIT_DONE) && i_sipo_done);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = SHIFT;
      end
      SHIFT: begin
        if (i_sipo_done) begin
          state_d = last_acc ? OUT : IDLE;
        end else if (last_acc) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_sipo_done) begin
          state_d = OUT;
        end else if (tcnt_q == TO_LAST) begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (i_m_ready) state_d = is_last ? IDLE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_s_ready    = (state_q == SHIFT);
    o_sipo_start = i_s_valid && (state_q == SHIFT);
    o_sipo_data  = i_s_data;
    o_m_valid    = (state_q == OUT);
    o_m_last     = (state_q == OUT) && is_last;
    o_busy       = (state_q != IDLE);
    o_m_data     = m_data_q;
    o_err        = err_q;
    o_frame_done = fdone_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_q    <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      m_data_q <= '0;
      err_q    <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      err_q   <= start_bad || to_hit || early_bad;
      fdone_q <= hs && is_last;
      if (capture) m_data_q <= i_sipo_data;
      if (start_ok) begin
        len_q  <= i_frame_len;
        wcnt_q <= '0;
        scnt_q <= '0;
      end
      if (accept) scnt_q <= scnt_q + 1'b1;
      if (last_acc) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT_DONE) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (hs && !is_last) begin
        wcnt_q <= wcnt_q + ONE_W;
        scnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with a behavioural 8-bit SIPO
// that shifts MSB-first and raises done the cycle after bit 8.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic [7:0] frame_len;
  logic       s_valid;
  logic       s_data;
  logic       s_ready;
  logic       sipo_start;
  logic       sipo_dat;
  logic [7:0] sipo_q;
  logic       sipo_done;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic       fdone;
  logic       err;

  logic       force_hi;
  logic       force_lo;
  logic [2:0] sc;
  logic       sd;
  int         n_starts;
  int         n_pass;
  int         n_chk;
  int         s0;

  sipo_frame_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(frame_start),
    .i_frame_len  (frame_len),
    .i_s_valid    (s_valid),
    .i_s_data     (s_data),
    .o_s_ready    (s_ready),
    .o_sipo_start (sipo_start),
    .o_sipo_data  (sipo_dat),
    .i_sipo_data  (sipo_q),
    .i_sipo_done  (sipo_done),
    .o_m_valid    (m_valid),
    .o_m_data     (m_data),
    .o_m_last     (m_last),
    .i_m_ready    (m_ready),
    .o_busy       (busy),
    .o_frame_done (fdone),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sipo_q <= '0;
      sc     <= '0;
      sd     <= 1'b0;
    end else begin
      sd <= 1'b0;
      if (sipo_start) begin
        sipo_q <= {sipo_q[6:0], sipo_dat};
        sc     <= sc + 3'd1;
        sd     <= (sc == 3'd7);
      end
    end
  end

  assign sipo_done = force_hi || (sd && !force_lo);

  initial n_starts = 0;
  always_ff @(posedge clk) begin
    if (sipo_start) n_starts <= n_starts + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w,
                      input int nb,
                      input int gap);
    for (int i = 0; i < nb; i++) begin
      s_valid = 1'b1;
      s_data  = w[7-i];
      #1;
      chk("start_on", 32'(sipo_start), 1);
      chk("data_pass", 32'(sipo_dat), 32'(w[7-i]));
      tick();
      s_valid = 1'b0;
      if (i < nb - 1) begin
        for (int g = 0; g < gap; g++) begin
          #1;
          chk("start_gap", 32'(sipo_start), 0);
          chk("ready_gap", 32'(s_ready), 1);
          tick();
        end
      end
    end
  endtask

  task automatic begin_frame(input logic [7:0] len);
    frame_start = 1'b1;
    frame_len   = len;
    tick();
    frame_start = 1'b0;
    frame_len   = '0;
  endtask

  task automatic get_word(input logic [7:0] exp, input logic lst);
    chk("wait_valid0", 32'(m_valid), 0);
    chk("wait_ready0", 32'(s_ready), 0);
    tick();
    chk("valid", 32'(m_valid), 1);
    chk("data", 32'(m_data), 32'(exp));
    chk("last", 32'(m_last), 32'(lst));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_chk = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    frame_len = '0;
    s_valid = 1'b0;
    s_data = 1'b0;
    m_ready = 1'b0;
    force_hi = 1'b0;
    force_lo = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fdone", 32'(fdone), 0);
    rst_n = 1'b1;
    tick();

    // frame of two words, backpressure on the first
    begin_frame(8'd2);
    chk("f1_busy", 32'(busy), 1);
    chk("f1_ready", 32'(s_ready), 1);
    send(8'hA5, 8, 0);
    get_word(8'hA5, 1'b0);
    s_valid = 1'b1;
    s_data = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", 32'(m_data), 32'hA5);
      chk("bp_last", 32'(m_last), 0);
      chk("bp_ready", 32'(s_ready), 0);
      chk("bp_start", 32'(sipo_start), 0);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("hs1_ready", 32'(s_ready), 1);
    chk("hs1_mvalid", 32'(m_valid), 0);
    chk("hs1_fdone", 32'(fdone), 0);
    begin_frame(8'd5);
    chk("busy_start_err", 32'(err), 0);
    send(8'h3C, 8, 0);
    get_word(8'h3C, 1'b1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("f1_fdone", 32'(fdone), 1);
    chk("f1_idle", 32'(busy), 0);
    tick();
    chk("f1_fdone_pulse", 32'(fdone), 0);

    // single word with valid gaps
    begin_frame(8'd1);
    s0 = n_starts;
    send(8'h96, 8, 2);
    get_word(8'h96, 1'b1);
    chk("gap_starts", 32'(n_starts - s0), 8);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("f2_fdone", 32'(fdone), 1);

    // done while idle is ignored
    force_hi = 1'b1;
    tick();
    force_hi = 1'b0;
    chk("idle_done_err", 32'(err), 0);
    chk("idle_done_busy", 32'(busy), 0);

    // zero length
    begin_frame(8'd0);
    chk("zl_err", 32'(err), 1);
    chk("zl_busy", 32'(busy), 0);
    chk("zl_ready", 32'(s_ready), 0);
    tick();
    chk("zl_err_pulse", 32'(err), 0);
    chk("zl_busy2", 32'(busy), 0);

    // done never arrives
    force_lo = 1'b1;
    begin_frame(8'd1);
    send(8'hFF, 8, 0);
    for (int k = 0; k < 3; k++) begin
      chk("to_wait_err", 32'(err), 0);
      chk("to_wait_busy", 32'(busy), 1);
      tick();
    end
    chk("to_wait_err", 32'(err), 0);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_idle", 32'(busy), 0);
    force_lo = 1'b0;
    tick();
    chk("to_err_pulse", 32'(err), 0);

    // done after only three symbols
    begin_frame(8'd1);
    send(8'hE0, 3, 0);
    force_hi = 1'b1;
    tick();
    force_hi = 1'b0;
    chk("ed_err", 32'(err), 1);
    chk("ed_idle", 32'(busy), 0);
    tick();
    chk("ed_err_pulse", 32'(err), 0);

    // reset in the middle of a word
    begin_frame(8'd1);
    send(8'h70, 3, 0);
    rst_n = 1'b0;
    s_valid = 1'b1;
    tick();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(s_ready), 0);
    chk("mr_start", 32'(sipo_start), 0);
    chk("mr_mdata", 32'(m_data), 0);
    chk("mr_err", 32'(err), 0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("mr_err2", 32'(err), 0);
    begin_frame(8'd1);
    send(8'hC3, 8, 0);
    get_word(8'hC3, 1'b1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("mr_fdone", 32'(fdone), 1);
    chk("mr_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
